// File: rtl/rpeak_frame_tx.sv
// rpeak_frame_tx: queues R-peak detection events and streams each one as a checksummed byte frame
//
// Each detection event (sample number, RR period, QRS threshold) is stored in a small FIFO.
// The event is then sent as a byte frame on a valid/ready interface:
//   A5, S[23:16], S[15:8], S[7:0], R[15:8], R[7:0], [T[15:8], T[7:0]], CK
// CK is the XOR of every byte between the sync byte and CK.
//
// Build option: when RPEAK_TX_THRESHOLD_EN is defined, the threshold bytes are included in the
// frame (9 bytes). Otherwise they are left out of the frame and the FIFO (7 bytes).
//
// Ports:
//   i_clk               clock
//   i_nrst              asynchronous active-low reset
//   i_event             single-cycle strobe; the three fields below hold a new detection
//   i_r_peak_sample_num sample index of the R peak (CTR_WIDTH)
//   i_rr_period         RR period in samples (DATA_WIDTH)
//   i_qrs_threshold     current QRS threshold (DATA_WIDTH)
//   o_data / o_valid    frame byte and its valid flag
//   i_ready             sink accepts o_data
//   o_last              current byte is the checksum, i.e. the end of the frame
//   o_busy              events are pending or a frame is in progress
//   o_drop_cnt          saturating count of events lost because the FIFO was full
module rpeak_frame_tx #(
    parameter int DATA_WIDTH = 11,
    parameter int CTR_WIDTH  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_event,
    input  logic [CTR_WIDTH-1:0]  i_r_peak_sample_num,
    input  logic [DATA_WIDTH-1:0] i_rr_period,
    input  logic [DATA_WIDTH-1:0] i_qrs_threshold,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic [7:0]            o_drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef RPEAK_TX_THRESHOLD_EN
    localparam int EW   = CTR_WIDTH + 2 * DATA_WIDTH;
    localparam int FLEN = 9;
`else
    localparam int EW   = CTR_WIDTH + DATA_WIDTH;
    localparam int FLEN = 7;
`endif
    localparam int IW = $clog2(FLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_frame [FLEN];
    logic [7:0]    r_drop_cnt;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_send;
    logic          w_last;
    logic          w_xfer;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_head;
    logic [23:0]   w_s24;
    logic [15:0]   w_r16;
    logic [7:0]    w_pl [FLEN-2];
    logic [7:0]    w_ck;

    // Fullness is judged on the registered count, so a pop in the same cycle cannot make room.
    assign w_full = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_push = i_event & ~w_full;
    assign w_pop  = r_state == S_LOAD;
    assign w_send = r_state == S_SEND;
    assign w_last = w_send & (r_idx == IW'(FLEN - 1));
    assign w_xfer = w_send & i_ready;

    assign w_head = r_mem[r_rd_ptr];
    assign w_s24  = 24'(w_head[EW-1 -: CTR_WIDTH]);
    assign w_r16  = 16'(w_head[EW-CTR_WIDTH-1 -: DATA_WIDTH]);

`ifdef RPEAK_TX_THRESHOLD_EN
    logic [15:0] w_t16;
    assign w_wr_entry = {i_r_peak_sample_num, i_rr_period, i_qrs_threshold};
    assign w_t16      = 16'(w_head[DATA_WIDTH-1:0]);
`else
    logic w_unused_th;
    assign w_wr_entry  = {i_r_peak_sample_num, i_rr_period};
    assign w_unused_th = ^i_qrs_threshold;
`endif

    // Payload = every frame byte between the sync byte and the checksum.
    always_comb begin
        w_pl[0] = w_s24[23:16];
        w_pl[1] = w_s24[15:8];
        w_pl[2] = w_s24[7:0];
        w_pl[3] = w_r16[15:8];
        w_pl[4] = w_r16[7:0];
`ifdef RPEAK_TX_THRESHOLD_EN
        w_pl[5] = w_t16[15:8];
        w_pl[6] = w_t16[7:0];
`endif
    end

    always_comb begin
        w_ck = 8'h00;
        for (int k = 0; k < FLEN - 2; k++) w_ck = w_ck ^ w_pl[k];
    end

    // Data storage needs no reset: the state and the count decide what is visible.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
        if (w_pop) begin
            r_frame[0] <= 8'hA5;
            for (int k = 1; k < FLEN - 1; k++) r_frame[k] <= w_pl[k-1];
            r_frame[FLEN-1] <= w_ck;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_drop_cnt <= 8'h00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (i_event && w_full && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            r_state <= (r_state == S_IDLE && r_count != '0) ? S_LOAD :
                       (r_state == S_LOAD)                  ? S_SEND :
                       (w_xfer && w_last)                   ? S_IDLE : r_state;
            r_idx   <= w_pop              ? '0 :
                       (w_xfer && !w_last) ? r_idx + 1'b1 : r_idx;
        end
    end

    assign o_valid    = w_send;
    assign o_data     = w_send ? r_frame[r_idx] : 8'h00;
    assign o_last     = w_last;
    assign o_busy     = (r_count != '0) | (r_state != S_IDLE);
    assign o_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_rpeak_frame_tx.sv
// tb_rpeak_frame_tx: scoreboard bench for rpeak_frame_tx driven by a table of detection events
module tb_rpeak_frame_tx;
    localparam int DW = 11;
    localparam int CW = 24;
`ifdef RPEAK_TX_THRESHOLD_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 7;
`endif

    typedef struct {
        logic [23:0] s;
        logic [10:0] r;
        logic [10:0] t;
        logic [7:0]  ck_en;
        logic [7:0]  ck_no;
    } vec_t;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          ev = 1'b0;
    logic          ready = 1'b0;
    logic [CW-1:0] s = '0;
    logic [DW-1:0] r = '0;
    logic [DW-1:0] t = '0;
    logic [7:0]    data;
    logic [7:0]    drop;
    logic          valid;
    logic          last;
    logic          busy;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [8:0]    sb[$];
    vec_t          tv[6];

    always #5 clk = ~clk;

    rpeak_frame_tx dut (
        .i_clk(clk),
        .i_nrst(nrst),
        .i_event(ev),
        .i_r_peak_sample_num(s),
        .i_rr_period(r),
        .i_qrs_threshold(t),
        .o_data(data),
        .o_valid(valid),
        .i_ready(ready),
        .o_last(last),
        .o_busy(busy),
        .o_drop_cnt(drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sb(input vec_t v);
        logic [15:0] r16;
`ifdef RPEAK_TX_THRESHOLD_EN
        logic [15:0] t16;
        t16 = 16'(v.t);
`endif
        r16 = 16'(v.r);
        sb.push_back({1'b0, 8'hA5});
        sb.push_back({1'b0, v.s[23:16]});
        sb.push_back({1'b0, v.s[15:8]});
        sb.push_back({1'b0, v.s[7:0]});
        sb.push_back({1'b0, r16[15:8]});
        sb.push_back({1'b0, r16[7:0]});
`ifdef RPEAK_TX_THRESHOLD_EN
        sb.push_back({1'b0, t16[15:8]});
        sb.push_back({1'b0, t16[7:0]});
        sb.push_back({1'b1, v.ck_en});
`else
        sb.push_back({1'b1, v.ck_no});
`endif
    endtask

    task automatic push_ev(input vec_t v);
        s  = v.s;
        r  = v.r;
        t  = v.t;
        ev = 1'b1;
        tick();
        ev = 1'b0;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && (sb.size() != 0 || busy); i++) tick();
        chk("drain pending bytes", 32'(sb.size()), 32'd0);
        chk("drain busy", 32'(busy), 32'd0);
    endtask

    // Every accepted byte must match the head of the scoreboard, including its o_last flag.
    always @(negedge clk) begin
        if (nrst && valid && ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected byte: got %0h with last=%0b, expected no transfer", data, last);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("frame byte {last,data}", 32'({last, data}), 32'(e));
            end
        end
    end

    initial begin
        int g;
        tv[0] = '{24'h000168, 11'h12C, 11'h050, 8'h14, 8'h44};
        tv[1] = '{24'hFFFFFF, 11'h7FF, 11'h7FF, 8'hFF, 8'h07};
        tv[2] = '{24'h000002, 11'h003, 11'h000, 8'h01, 8'h01};
        tv[3] = '{24'h123456, 11'h0AB, 11'h3CD, 8'h15, 8'hDB};
        tv[4] = '{24'h000000, 11'h000, 11'h000, 8'h00, 8'h00};
        tv[5] = '{24'hABCDEF, 11'h555, 11'h2AA, 8'h71, 8'hD9};

        repeat (2) tick();
        chk("reset o_data", 32'(data), 32'd0);
        chk("reset o_valid", 32'(valid), 32'd0);
        chk("reset o_last", 32'(last), 32'd0);
        chk("reset o_busy", 32'(busy), 32'd0);
        chk("reset o_drop_cnt", 32'(drop), 32'd0);
        nrst = 1'b1;
        tick();

        ready = 1'b1;
        push_sb(tv[0]);
        push_ev(tv[0]);
        chk("latency valid after edge 1", 32'(valid), 32'd0);
        tick();
        chk("latency valid after edge 2", 32'(valid), 32'd0);
        tick();
        chk("latency valid after edge 3", 32'(valid), 32'd1);
        chk("busy while sending", 32'(busy), 32'd1);
        drain(100);

        for (int i = 0; i < 6; i++) begin
            push_sb(tv[i]);
            push_ev(tv[i]);
            drain(100);
        end

        push_sb(tv[1]);
        push_sb(tv[2]);
        push_ev(tv[1]);
        push_ev(tv[2]);
        for (int i = 0; i < 60 && !(valid && last); i++) tick();
        chk("b2b first frame end seen", 32'(valid && last), 32'd1);
        g = 0;
        tick();
        while (!valid && g < 20) begin
            g++;
            tick();
        end
        chk("b2b idle cycles", 32'(g), 32'd2);
        drain(100);

        push_sb(tv[0]);
        push_ev(tv[0]);
        for (int i = 0; i < 20 && !(valid && data == 8'h68); i++) tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall o_data", 32'(data), 32'h68);
            chk("stall o_valid", 32'(valid), 32'd1);
            chk("stall o_last", 32'(last), 32'd0);
        end
        ready = 1'b1;
        drain(100);

        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) push_sb(tv[i % 6]);
            push_ev(tv[i % 6]);
            tick();
        end
        chk("overflow drop count", 32'(drop), 32'd2);
        chk("overflow busy", 32'(busy), 32'd1);
        ready = 1'b1;
        drain(300);
        chk("drop count kept after drain", 32'(drop), 32'd2);

        ready = 1'b0;
        for (int i = 0; i < 305; i++) begin
            push_ev(tv[i % 6]);
            tick();
        end
        chk("saturated drop count", 32'(drop), 32'd255);
        nrst = 1'b0;
        #1;
        chk("reset clears drop count", 32'(drop), 32'd0);
        chk("reset clears busy", 32'(busy), 32'd0);
        tick();
        nrst = 1'b1;
        tick();

        ready = 1'b1;
        push_sb(tv[3]);
        push_ev(tv[3]);
        for (int i = 0; i < 40 && sb.size() > FLEN - 4; i++) tick();
        chk("bytes left before reset", 32'(sb.size()), 32'(FLEN - 4));
        nrst = 1'b0;
        #1;
        chk("midframe reset o_data", 32'(data), 32'd0);
        chk("midframe reset o_valid", 32'(valid), 32'd0);
        chk("midframe reset o_last", 32'(last), 32'd0);
        chk("midframe reset o_busy", 32'(busy), 32'd0);
        chk("midframe reset o_drop_cnt", 32'(drop), 32'd0);
        sb.delete();
        tick();
        nrst = 1'b1;
        tick();
        push_sb(tv[0]);
        push_ev(tv[0]);
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
